// File: rtl/cdb_arbiter_pkg.sv
// Shared machine constants for the CDB arbiter and its helpers.
package cdb_arbiter_pkg;

  localparam int unsigned FUNCTION_UNIT_NUMBER     = 8;
  localparam int unsigned FUNCTION_UNIT_NUMBER_LOG = 3;
  localparam int unsigned REORDER_BUFFER_SIZE_LOG  = 4;
  localparam int unsigned CDB_DATA_WIDTH           = 32;

endpackage

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set bit of mask_i at or above start_i, wrapping.
module rr_priority_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N     = FUNCTION_UNIT_NUMBER,
  parameter int unsigned N_LOG = FUNCTION_UNIT_NUMBER_LOG
) (
  input  logic [N-1:0]     mask_i,
  input  logic [N_LOG-1:0] start_i,
  output logic             found_c,
  output logic [N_LOG-1:0] idx_c
);

  logic [N-1:0]     rot_c;
  logic [N_LOG-1:0] off_c;
  logic [N_LOG:0]   sum_c;

  // Rotate so bit start_i lands at position 0; the doubled copy supplies the wrap.
  assign rot_c = N'({mask_i, mask_i} >> start_i);

  // Lowest set bit of the rotated mask is the offset from start_i.
  always_comb begin
    found_c = 1'b0;
    off_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot_c[i]) begin
        found_c = 1'b1;
        off_c   = N_LOG'(i);
      end
    end
  end

  // Map the offset back to an absolute index with an explicit modulo-N wrap.
  always_comb begin
    sum_c = {1'b0, start_i} + (N_LOG + 1)'(off_c);
    if (sum_c >= (N_LOG + 1)'(N)) begin
      sum_c = sum_c - (N_LOG + 1)'(N);
    end
    idx_c = sum_c[N_LOG-1:0];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one function-unit result per cycle to CDB and ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM     = FUNCTION_UNIT_NUMBER,
  parameter int unsigned FU_NUM_LOG = FUNCTION_UNIT_NUMBER_LOG,
  parameter int unsigned ROB_LOG    = REORDER_BUFFER_SIZE_LOG,
  parameter int unsigned DATA_W     = CDB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FU_NUM-1:0]        req,
  input  logic [FU_NUM*ROB_LOG-1:0] req_pos,
  input  logic [FU_NUM*DATA_W-1:0] req_value,
  input  logic                     rob_ready,
  input  logic                     flush,
  output logic [FU_NUM-1:0]        ack,
  output logic                     cdb_valid,
  output logic [FU_NUM_LOG-1:0]    cdb_tag,
  output logic [ROB_LOG-1:0]       cdb_pos,
  output logic [DATA_W-1:0]        cdb_value
);

  logic [FU_NUM-1:0]     ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [FU_NUM_LOG-1:0] tag_q, tag_d;
  logic [ROB_LOG-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]     value_q, value_d;
  logic [FU_NUM_LOG-1:0] rr_ptr_q, rr_ptr_d;

  logic                  slot_free_c;
  logic [FU_NUM-1:0]     elig_c;
  logic [FU_NUM_LOG-1:0] start_c;
  logic                  found_c;
  logic [FU_NUM_LOG-1:0] grant_c;
  logic [ROB_LOG-1:0]    sel_pos_c;
  logic [DATA_W-1:0]     sel_value_c;

  // A unit acked this cycle still has req high; mask it so it is not granted twice.
  assign slot_free_c = !valid_q || rob_ready;
  assign elig_c      = req & ~ack_q;
  assign start_c     = (rr_ptr_q == FU_NUM_LOG'(FU_NUM - 1)) ? '0 : rr_ptr_q + FU_NUM_LOG'(1);

  rr_priority_pick #(
    .N     (FU_NUM),
    .N_LOG (FU_NUM_LOG)
  ) u_pick (
    .mask_i  (elig_c),
    .start_i (start_c),
    .found_c (found_c),
    .idx_c   (grant_c)
  );

  // Select the granted unit's ROB position and value slices.
  always_comb begin
    sel_pos_c   = '0;
    sel_value_c = '0;
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      if (grant_c == FU_NUM_LOG'(i)) begin
        sel_pos_c   = req_pos[i*ROB_LOG +: ROB_LOG];
        sel_value_c = req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: flush overrides, a stalled word holds, otherwise grant or go idle.
  always_comb begin
    ack_d    = '0;
    valid_d  = valid_q;
    tag_d    = tag_q;
    pos_d    = pos_q;
    value_d  = value_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (slot_free_c) begin
      if (found_c) begin
        valid_d  = 1'b1;
        tag_d    = grant_c;
        pos_d    = sel_pos_c;
        value_d  = sel_value_c;
        ack_d    = FU_NUM'(1) << grant_c;
        rr_ptr_d = grant_c;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; the pointer resets to the last unit so unit 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q    <= '0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      pos_q    <= '0;
      value_q  <= '0;
      rr_ptr_q <= FU_NUM_LOG'(FU_NUM - 1);
    end else begin
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      pos_q    <= pos_d;
      value_q  <= value_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign ack       = ack_q;
  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_pos   = pos_q;
  assign cdb_value = value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_cdb_arbiter;

  localparam int N  = 8;
  localparam int NL = 3;
  localparam int RL = 4;
  localparam int DW = 32;
  localparam int N2 = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*RL-1:0] req_pos = '0;
  logic [N*DW-1:0] req_value = '0;
  logic          rob_ready = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  ack;
  logic          cdb_valid;
  logic [NL-1:0] cdb_tag;
  logic [RL-1:0] cdb_pos;
  logic [DW-1:0] cdb_value;

  logic [N2-1:0]    req2 = '0;
  logic [N2*RL-1:0] req_pos2 = '0;
  logic [N2*DW-1:0] req_value2 = '0;
  logic             rob2 = 1'b1;
  logic             flush2 = 1'b0;
  logic [N2-1:0]    ack2;
  logic             cdb_valid2;
  logic [NL-1:0]    cdb_tag2;
  logic [RL-1:0]    cdb_pos2;
  logic [DW-1:0]    cdb_value2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.FU_NUM(N), .FU_NUM_LOG(NL), .ROB_LOG(RL), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_pos(req_pos), .req_value(req_value),
    .rob_ready(rob_ready), .flush(flush), .ack(ack), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_pos(cdb_pos), .cdb_value(cdb_value)
  );

  cdb_arbiter #(.FU_NUM(N2), .FU_NUM_LOG(NL), .ROB_LOG(RL), .DATA_W(DW)) dut6 (
    .clk(clk), .reset(reset), .req(req2), .req_pos(req_pos2), .req_value(req_value2),
    .rob_ready(rob2), .flush(flush2), .ack(ack2), .cdb_valid(cdb_valid2),
    .cdb_tag(cdb_tag2), .cdb_pos(cdb_pos2), .cdb_value(cdb_value2)
  );

  // ---------------- behavioural model of the 8-unit instance ----------------
  logic [N-1:0]  m_ack;
  logic          m_valid;
  logic [NL-1:0] m_tag;
  logic [RL-1:0] m_pos;
  logic [DW-1:0] m_value;
  int            m_rr;
  int            m_g;

  // First eligible unit scanning upward from one past the last grant, wrapping.
  function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] a, input int rr);
    for (int k = 1; k <= N; k++) begin
      int u;
      u = (rr + k) % N;
      if (r[u] && !a[u]) return u;
    end
    return -1;
  endfunction

  always_comb m_g = pick(req, m_ack, m_rr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rr <= N - 1; m_ack <= '0; m_valid <= 1'b0;
      m_tag <= '0; m_pos <= '0; m_value <= '0;
    end else if (flush) begin
      m_valid <= 1'b0; m_ack <= '0;
    end else if (m_valid && !rob_ready) begin
      m_ack <= '0;
    end else if (m_g < 0) begin
      m_valid <= 1'b0; m_ack <= '0;
    end else begin
      m_valid <= 1'b1;
      m_ack   <= N'(1) << m_g;
      m_rr    <= m_g;
      m_tag   <= NL'(m_g);
      m_pos   <= req_pos[m_g*RL +: RL];
      m_value <= req_value[m_g*DW +: DW];
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ({ack, cdb_valid, cdb_tag, cdb_pos, cdb_value} !== {m_ack, m_valid, m_tag, m_pos, m_value}) begin
        errors++;
        $display("FAIL model_cycle t=%0t ack=%h/%h valid=%b/%b tag=%0d/%0d pos=%0d/%0d value=%h/%h (got/required)",
                 $time, ack, m_ack, cdb_valid, m_valid, cdb_tag, m_tag, cdb_pos, m_pos, cdb_value, m_value);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic set_unit(input int i, input logic [RL-1:0] p, input logic [DW-1:0] v);
    req_pos[i*RL +: RL]   = p;
    req_value[i*DW +: DW] = v;
  endtask

  logic flush_prev;

  initial begin
    // ---- reset values ----
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(cdb_valid), 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_tag_pos_val", {cdb_tag, cdb_pos, cdb_value}, 0);
    chk("rst6_valid", 64'(cdb_valid2), 0);
    reset = 1'b1;

    // ---- single request; 6-unit wrap from pointer 5 ----
    req = 8'b0000_0100; set_unit(2, 4'd3, 32'd12);
    req2 = 6'b100001;
    req_pos2[0 +: RL] = 4'd1;  req_value2[0 +: DW] = 32'd100;
    req_pos2[5*RL +: RL] = 4'd9; req_value2[5*DW +: DW] = 32'd500;
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid), 1);
    chk("single_tag", 64'(cdb_tag), 2);
    chk("single_pos", 64'(cdb_pos), 3);
    chk("single_value", 64'(cdb_value), 12);
    chk("single_ack", 64'(ack), 64'h04);
    chk("wrap6_first_tag", 64'(cdb_tag2), 0);
    chk("wrap6_first_ack", 64'(ack2), 64'h01);
    req = '0;
    @(negedge clk);
    chk("single_idle_valid", 64'(cdb_valid), 0);
    chk("wrap6_second_tag", 64'(cdb_tag2), 5);
    chk("wrap6_second_value", 64'(cdb_value2), 500);
    chk("wrap6_second_ack", 64'(ack2), 64'h20);
    req2 = '0;

    // ---- backpressure ----
    req = 8'h20; set_unit(5, 4'd7, 32'd35);
    @(negedge clk);
    chk("bp_grant_tag", 64'(cdb_tag), 5);
    chk("bp_grant_ack", 64'(ack), 64'h20);
    req = 8'h40; set_unit(6, 4'd8, 32'd66); rob_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 3'd5, 32'd35});
      chk("bp_hold_ack", 64'(ack), 0);
    end
    rob_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_tag", 64'(cdb_tag), 6);
    chk("bp_next_ack", 64'(ack), 64'h40);
    req = '0;
    @(negedge clk);
    chk("bp_idle", 64'(cdb_valid), 0);

    // ---- flush ----
    req = 8'h02; set_unit(1, 4'd1, 32'd11);
    @(negedge clk);
    chk("fl_on_bus", 64'(cdb_tag), 1);
    req = 8'h18; set_unit(3, 4'd3, 32'd33); set_unit(4, 4'd4, 32'd44); flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", 64'(cdb_valid), 0);
    chk("fl_ack", 64'(ack), 0);
    flush = 1'b0;
    @(negedge clk);
    chk("fl_after_tag3", {cdb_valid, cdb_tag, ack}, {1'b1, 3'd3, 8'h08});
    req = 8'h10;
    @(negedge clk);
    chk("fl_after_tag4", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 3'd4, 32'd44});
    req = '0;
    @(negedge clk);

    // ---- asynchronous reset mid-transfer ----
    req = 8'hFF;
    for (int i = 0; i < N; i++) set_unit(i, RL'(i), DW'(100 + i));
    @(negedge clk);
    chk("ar_busy", 64'(cdb_valid), 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_outputs_zero", {ack, cdb_valid, cdb_tag, cdb_pos, cdb_value}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar_first_grant", {cdb_tag, ack, cdb_value}, {3'd0, 8'h01, 32'd100});

    // ---- round robin with all units requesting ----
    for (int k = 1; k <= N; k++) begin
      req = ~(N'(1) << ((k - 1) % N));
      @(negedge clk);
      chk("rr_tag", 64'(cdb_tag), 64'(k % N));
      chk("rr_ack", 64'(ack), 64'(N'(1) << (k % N)));
    end
    req = '0;
    @(negedge clk);

    // ---- random traffic, checked by the model every cycle ----
    flush_prev = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (flush_prev) begin
        req = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ack[i]) begin
            req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(2) == 0) begin
            req[i] = 1'b1;
            set_unit(i, RL'($urandom), $urandom);
          end
        end
      end
      rob_ready  = ($urandom_range(3) != 0);
      flush      = ($urandom_range(31) == 0);
      flush_prev = flush;
      @(negedge clk);
    end
    req = '0; flush = 1'b0; rob_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
